lock_pw_config_ctrl: RTL

Password-programming controller for the digital lock. While the lock reports unlocked, it sequences the user through entering a new 4-digit password and then confirming it. It owns the 16-bit password register that feeds the lock FSM's password input. Key inputs are the debounced single-cycle button pulses already generated at top level; timeouts are counted on the shared 25 Hz tick.

---
 rtl/lock_pw_config_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lock_pw_config_ctrl.sv
// Password-programming controller for the digital lock.
// While the lock is open, walks the user through entering and confirming
// a new 4-digit one-hot password, then commits it to the password register
// that feeds the lock FSM.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for prog_req; keys ignored
// ENTER   | capturing the four digits of the new password into new_buf
// CONFIRM | capturing the four confirmation digits into conf_buf
// COMMIT  | one cycle: compare buffers, update password or flag error
module lock_pw_config_ctrl #(
  parameter logic [15:0] DEFAULT_PW    = 16'h4121,
  parameter int          TIMEOUT_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_pulse,
  input  logic        prog_req,
  input  logic        unlocked,
  input  logic        tick,
  output logic [15:0] password,
  output logic        cfg_busy,
  output logic [2:0]  digit_cnt,
  output logic        phase,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, ENTER, CONFIRM, COMMIT} state_t;

  // Inactivity timer runs down from TIMER_LOAD; a tick at zero is the timeout.
  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT_TICKS - 1);

  state_t      state, state_n;
  logic [15:0] new_buf, new_buf_n, conf_buf, conf_buf_n, password_n;
  logic [7:0]  timer, timer_n;
  logic [2:0]  digit_cnt_n;
  logic        phase_n, done_n, err_n, busy_n;
  logic [1:0]  code_n;
  logic        key_onehot, key_bad, abort;
  logic [1:0]  abort_code;
  logic [15:0] key_nib;

  assign key_onehot = (btn_pulse != 4'd0) && ((btn_pulse & (btn_pulse - 4'd1)) == 4'd0);
  assign key_bad    = (btn_pulse != 4'd0) && !key_onehot;
  // Digit 0 lands in [15:12], digit 3 in [3:0].
  assign key_nib    = {btn_pulse, 12'h000} >> {digit_cnt[1:0], 2'b00};

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_n     = state;
    new_buf_n   = new_buf;
    conf_buf_n  = conf_buf;
    timer_n     = timer;
    digit_cnt_n = digit_cnt;
    phase_n     = phase;
    password_n  = password;
    done_n      = 1'b0;
    err_n       = 1'b0;
    code_n      = err_code;
    abort       = 1'b0;
    abort_code  = 2'd0;
    case (state)
      IDLE: begin
        if (prog_req) begin
          if (unlocked) begin
            state_n     = ENTER;
            digit_cnt_n = 3'd0;
            timer_n     = TIMER_LOAD;
            phase_n     = 1'b0;
          end else begin
            err_n  = 1'b1;
            code_n = 2'd3;
          end
        end
      end
      ENTER, CONFIRM: begin
        if (!unlocked) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (key_bad) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end else if (key_onehot) begin
          timer_n = TIMER_LOAD;
          if (state == ENTER) new_buf_n  = new_buf | key_nib;
          else                conf_buf_n = conf_buf | key_nib;
          if (digit_cnt == 3'd3) begin
            if (state == ENTER) begin
              state_n     = CONFIRM;
              digit_cnt_n = 3'd0;
              phase_n     = 1'b1;
            end else begin
              state_n     = COMMIT;
              digit_cnt_n = 3'd4;
            end
          end else begin
            digit_cnt_n = digit_cnt + 3'd1;
          end
        end else if (tick) begin
          if (timer == 8'd0) begin
            abort      = 1'b1;
            abort_code = 2'd1;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
      end
      COMMIT: begin
        if (new_buf == conf_buf) begin
          password_n = new_buf;
          done_n     = 1'b1;
        end else begin
          err_n  = 1'b1;
          code_n = 2'd0;
        end
        state_n     = IDLE;
        new_buf_n   = 16'd0;
        conf_buf_n  = 16'd0;
        digit_cnt_n = 3'd0;
        phase_n     = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n     = IDLE;
      new_buf_n   = 16'd0;
      conf_buf_n  = 16'd0;
      digit_cnt_n = 3'd0;
      phase_n     = 1'b0;
      err_n       = 1'b1;
      code_n      = abort_code;
    end
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      new_buf   <= 16'd0;
      conf_buf  <= 16'd0;
      timer     <= TIMER_LOAD;
      digit_cnt <= 3'd0;
      phase     <= 1'b0;
      password  <= DEFAULT_PW;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_n;
      new_buf   <= new_buf_n;
      conf_buf  <= conf_buf_n;
      timer     <= timer_n;
      digit_cnt <= digit_cnt_n;
      phase     <= phase_n;
      password  <= password_n;
      cfg_busy  <= busy_n;
      cfg_done  <= done_n;
      cfg_err   <= err_n;
      err_code  <= code_n;
    end
  end

endmodule
